// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one synchronous single-port memory (1-cycle read latency) between the
// processor's instruction-fetch port and its data port. Each cycle the arbiter
// picks at most one winner, answers the loser with Waitreq, steers the winner's
// address / write data / write enable to the memory and raises the matching
// RdValid one cycle after every granted read.
//
// Handshake (both processor ports): a request (InstrRead, or DataRead|DataWrite)
// is accepted in a cycle where it is high and its Waitreq is 0. The requester
// holds address and write data stable until that cycle. Waitreq is never high
// without a request.
//
// Optional build macro: MEM_ARBITER_FAIRNESS_EN
//   undefined : data port always wins; a fetch may wait indefinitely.
//   defined   : after MAX_DATA_STREAK consecutive data grants taken while a
//               fetch waited, the fetch wins the next contested cycle.
//
// Ports
//   Clock, Reset        rising-edge clock, asynchronous active-low reset
//   Enable              0 = issue no grant this cycle
//   InstrAddr/InstrRead fetch request; InstrWaitreq back-pressure
//   InstrRdValid/Data   fetch return (data = memory q)
//   DataAddr/DataRead/DataWrite/DataOut  load/store request
//   DataWaitreq         load/store back-pressure
//   DataRdValid/Data    load return (data = memory q)
//   MemAddr/MemWrData/MemWrite/MemRdData shared memory port
//   owner_dbg_o         owner state (0 IDLE, 1 INSTR, 2 DATA) for observation
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int DATA_W          = 16,
   parameter int ADDR_W          = 16,
   parameter int MEM_ADDR_W      = 12,
   parameter int MAX_DATA_STREAK = 4
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  Enable,
   // instruction-fetch port
   input  logic [ADDR_W-1:0]     InstrAddr,
   input  logic                  InstrRead,
   output logic                  InstrWaitreq,
   output logic                  InstrRdValid,
   output logic [DATA_W-1:0]     InstrRdData,
   // data port
   input  logic [ADDR_W-1:0]     DataAddr,
   input  logic                  DataRead,
   input  logic                  DataWrite,
   input  logic [DATA_W-1:0]     DataOut,
   output logic                  DataWaitreq,
   output logic                  DataRdValid,
   output logic [DATA_W-1:0]     DataRdData,
   // shared memory port
   output logic [MEM_ADDR_W-1:0] MemAddr,
   output logic [DATA_W-1:0]     MemWrData,
   output logic                  MemWrite,
   input  logic [DATA_W-1:0]     MemRdData,
   // state observation
   output logic [1:0]            owner_dbg_o
);

   typedef enum logic [1:0] {
      OWN_IDLE  = 2'd0,
      OWN_INSTR = 2'd1,
      OWN_DATA  = 2'd2
   } owner_e;

   owner_e                owner_q, owner_d;
   logic                  data_rd_q, data_rd_d;
   logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;

   logic ireq, dreq, grant_ok;
   logic instr_gnt, data_gnt;
   logic instr_first;

   // Address bits above the memory's range are intentionally dropped.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{InstrAddr[ADDR_W-1:MEM_ADDR_W],
                               DataAddr[ADDR_W-1:MEM_ADDR_W]};

   // --------------------------------------------------------------------------
   // Fairness streak
   // --------------------------------------------------------------------------
`ifdef MEM_ARBITER_FAIRNESS_EN
   localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

   logic [STREAK_W-1:0] streak_q, streak_d;

   // A waiting fetch that has already been passed over MAX_DATA_STREAK times
   // takes this cycle even if the data port is requesting.
   assign instr_first = ireq & (streak_q == STREAK_MAX);

   always_comb begin
      streak_d = streak_q;
      if (!ireq || instr_gnt) begin
         streak_d = '0;
      end else if (data_gnt && (streak_q != STREAK_MAX)) begin
         streak_d = streak_q + 1'b1;
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         streak_q <= '0;
      end else begin
         streak_q <= streak_d;
      end
   end
`else
   logic unused_streak_param;
   assign unused_streak_param = ^32'(MAX_DATA_STREAK);
   assign instr_first         = 1'b0;
`endif

   // --------------------------------------------------------------------------
   // Arbitration
   // --------------------------------------------------------------------------
   always_comb begin
      ireq     = InstrRead;
      dreq     = DataRead | DataWrite;
      // Reset is checked here too so nothing is granted while it is held low.
      grant_ok = Reset & Enable;

      data_gnt  = grant_ok & dreq & ~instr_first;
      instr_gnt = grant_ok & ireq & ~data_gnt;
   end

   assign InstrWaitreq = ireq & ~instr_gnt;
   assign DataWaitreq  = dreq & ~data_gnt;

   // --------------------------------------------------------------------------
   // Memory steering
   // --------------------------------------------------------------------------
   always_comb begin
      mem_addr_d = mem_addr_q;
      MemWrData  = '0;
      MemWrite   = 1'b0;
      if (data_gnt) begin
         mem_addr_d = DataAddr[MEM_ADDR_W-1:0];
         MemWrData  = DataOut;
         // Read and write together is a write.
         MemWrite   = DataWrite;
      end else if (instr_gnt) begin
         mem_addr_d = InstrAddr[MEM_ADDR_W-1:0];
      end
   end

   // With no grant the memory keeps seeing the last granted address.
   assign MemAddr = mem_addr_d;

   // --------------------------------------------------------------------------
   // Owner FSM: records last cycle's winner, which selects the return path.
   // Every state moves to the current winner, or IDLE when nothing is granted.
   // --------------------------------------------------------------------------
   always_comb begin
      owner_d   = OWN_IDLE;
      data_rd_d = 1'b0;
      case (owner_q)
         OWN_IDLE, OWN_INSTR, OWN_DATA: begin
            if (data_gnt) begin
               owner_d   = OWN_DATA;
               data_rd_d = ~DataWrite;
            end else if (instr_gnt) begin
               owner_d   = OWN_INSTR;
            end
         end
         default: begin
            owner_d = OWN_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         owner_q    <= OWN_IDLE;
         data_rd_q  <= 1'b0;
         mem_addr_q <= '0;
      end else begin
         owner_q    <= owner_d;
         data_rd_q  <= data_rd_d;
         mem_addr_q <= mem_addr_d;
      end
   end

   // --------------------------------------------------------------------------
   // Read return: memory q is valid the cycle after the grant.
   // --------------------------------------------------------------------------
   assign InstrRdValid = (owner_q == OWN_INSTR);
   assign DataRdValid  = (owner_q == OWN_DATA) & data_rd_q;
   assign InstrRdData  = MemRdData;
   assign DataRdData   = MemRdData;
   assign owner_dbg_o  = owner_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one synchronous single-port memory (1-cycle read latency, inst_mem style) between the processor's instruction-fetch port and its data port.
- Arbitrates each cycle and drives InstrWaitreq / DataWaitreq back to the processor.
- Steers address, write data and write enable to the memory, and flags read-data return one cycle after each granted read.
- Sits between processor and the shared inst_mem instance.

Parameters:
- DATA_W, 16, data word width
- ADDR_W, 16, processor address width
- MEM_ADDR_W, 12, memory address width; MemAddr = winner address[MEM_ADDR_W-1:0]
- MAX_DATA_STREAK, 4, consecutive data grants allowed while an instruction request waits (fairness build only)

Ports:
- Clock  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-low reset
- Enable  input  1  0 = no grants issued this cycle
- InstrAddr  input  ADDR_W  fetch address, held until granted
- InstrRead  input  1  fetch request
- InstrWaitreq  output  1  1 = fetch not accepted this cycle
- InstrRdValid  output  1  fetch data valid on InstrRdData
- InstrRdData  output  DATA_W  fetch return data
- DataAddr  input  ADDR_W  load/store address, held until granted
- DataRead  input  1  load request
- DataWrite  input  1  store request
- DataOut  input  DATA_W  store data
- DataWaitreq  output  1  1 = load/store not accepted this cycle
- DataRdValid  output  1  load data valid on DataRdData
- DataRdData  output  DATA_W  load return data
- MemAddr  output  MEM_ADDR_W  memory address
- MemWrData  output  DATA_W  memory write data
- MemWrite  output  1  memory write enable
- MemRdData  input  DATA_W  memory q, valid the cycle after the address

Behaviour:
- Requests: Ireq = InstrRead; Dreq = DataRead | DataWrite. A request is granted in the cycle its Waitreq is 0 while its request is high (Avalon-style). Requesters hold address and data until granted.
- Arbitration (combinational on current inputs and registered state):
  - No grant when Reset = 0 or Enable = 0.
  - Otherwise data wins over instruction.
  - Waitreq = request & ~grant.
  - With no request, Waitreq = 0.
- Memory steering:
  - MemAddr / MemWrData come from the granted port.
  - With no grant, MemAddr holds the last granted address (registered) and MemWrite = 0.
  - MemWrite = data grant & DataWrite.
  - DataRead & DataWrite both high: treated as a write; no DataRdValid is generated.
- Read return:
  - InstrRdValid <= instr grant; DataRdValid <= data grant & ~DataWrite (registered, 1 cycle).
  - InstrRdData = DataRdData = MemRdData (combinational); sampled only when the matching valid is 1.
  - Back-to-back grants give one return per cycle, in grant order.
- State:
  - owner register, one of IDLE / INSTR / DATA, records the last cycle's winner and selects the return path.
  - IDLE -> INSTR or DATA on grant; any state -> IDLE on a no-grant cycle.
  - streak counter, $clog2(MAX_DATA_STREAK+1) bits: increments on a data grant while Ireq is high, saturating at MAX_DATA_STREAK; clears on an instruction grant or when Ireq is low.
- Reset (async, Reset = 0): owner = IDLE, streak = 0, InstrRdValid = 0, DataRdValid = 0, registered MemAddr = 0, MemWrite = 0.
  - A read granted in the cycle before reset produces no valid after reset.
  - Waitreq = request while reset is asserted.
- Enable = 0 mid-stream: a pending RdValid from the previous grant still fires; no new grants.

Optional Feature:
- Macro: MEM_ARBITER_FAIRNESS_EN.
- Defined: when streak == MAX_DATA_STREAK and Ireq = 1, the instruction port wins that cycle over a data request; streak then clears.
- Undefined: strict data priority; the streak counter is not built, and the instruction port may starve indefinitely.

Test Plan:
- Reset low, InstrRead = 1 -> InstrWaitreq = 1, both RdValid = 0, MemWrite = 0. Release reset -> fetch of 0x0010 granted, MemAddr = 0x010, InstrRdValid = 1 next cycle with InstrRdData = mem[0x010].
- Simultaneous InstrRead @0x004 and DataRead @0x100 -> cycle 0: data granted, InstrWaitreq = 1. Cycle 1: DataRdValid = 1, instr granted. Cycle 2: InstrRdValid = 1.
- DataWrite @0x200, DataOut = 0xBEEF -> MemWrite = 1 for exactly 1 cycle, no DataRdValid. A later DataRead @0x200 returns 0xBEEF.
- Fairness build, MAX_DATA_STREAK = 4, continuous data requests plus pending fetch -> 4 data grants, then 1 instr grant, then data resumes. Non-fairness build -> fetch never granted over 20 cycles.
- Enable = 0 for 3 cycles with both requests high -> both Waitreq = 1, MemWrite = 0, no valids. Enable = 1 -> normal arbitration resumes.
- Reset asserted the cycle after a granted DataRead -> DataRdValid stays 0 and owner = IDLE.
